restriction_sweep_driver: RTL and testbench
===========================================

# restriction_sweep_driver

Sequential stimulus and response stage wrapped around a combinational restricted-PLA function (23 inputs `x0..x22`, one output `y0`). It walks every point of a configured affine subspace of the input space, `x = b0 ^ (c1·b1) ^ … ^ (cK·bK)`, in Gray-code order and drives each point onto the function's inputs. It samples `y0` for every point and compacts the responses into a ones count and a MISR signature. Used to characterise and cross-check restrictions without a full 2^23 sweep.

## Interface
Parameters:
- `N_IN`, 23, width of the function input vector.
- `K`, 8, subspace dimension; the sweep covers 2^K points. Legal range 1..16.
- `SIG_W`, 32, MISR width.

Ports:
- `clk` input 1: single clock; every register is on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `cfg_we` input 1: basis write strobe; ignored while `busy`.
- `cfg_idx` input `$clog2(K+1)`: 0 selects offset `b0`; 1..K select `b1..bK`. Indices above K are ignored.
- `cfg_data` input `N_IN`: basis or offset vector to write.
- `start` input 1: one-cycle request to begin a sweep; ignored while `busy`.
- `x_out` output `N_IN`: current point; connects to `x0..x22`, with bit i driving `xi`.
- `x_valid` output 1: `x_out` holds a valid point.
- `x_ready` input 1: consumer accepts the point; the transfer occurs when `x_valid & x_ready`.
- `y_in` input 1: function output for the current `x_out`. Sampled on the transfer cycle.
- `busy` output 1: a sweep is in progress.
- `done` output 1: the last sweep completed. Held until the next accepted `start` or reset.
- `ones_count` output K+1: number of transfers with `y_in=1`.
- `signature` output `SIG_W`: MISR state.

## Operation
- Basis/offset register file: K+1 entries of `N_IN` bits. Reset value 0.
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → DONE on the transfer of point 2^K−1.
  - DONE → RUN on `start`.
  - Reset forces IDLE.
- On entering RUN:
  - `cnt` = 0, `x_out` = `b0`.
  - `ones_count` = 0, `signature` = 0.
  - `done` = 0.
- On each transfer with `cnt` < 2^K−1:
  - `j` = index of the lowest set bit of `cnt+1`.
  - `x_out` ^= `b[j+1]`.
  - `cnt` increments.
  - Exactly one basis vector is applied per step; point n is therefore `b0 ^` XOR of `b[i+1]` over the set bits i of `gray(n)`.
- Accumulation on every transfer:
  - `ones_count` += `y_in`.
  - `signature` = (`signature` << 1) ^ (`signature[SIG_W-1]` ? `MISR_POLY` : 0) ^ `y_in`.
- Arithmetic: `ones_count` is K+1 bits, so 2^K ones never overflow. `cnt` is K bits.
- `cfg_we` and `start` on the same IDLE/DONE edge: the write commits, but the sweep starts with the pre-write value of that entry.
- Dependent or zero basis vectors are legal. Points then repeat and are counted as many times as they occur.

## Timing
- Reset values: `x_out`=0, `x_valid`=0, `busy`=0, `done`=0, `ones_count`=0, `signature`=0.
- `start` at edge t: `busy`=1, `x_valid`=1, `x_out`=`b0` visible after t.
- `x_valid` stays high throughout RUN, including cycles with `x_ready`=0.
- `x_out` is stable while `x_valid & !x_ready`. The next point appears the cycle after a transfer.
- With `x_ready` tied high, the sweep takes exactly 2^K cycles.
- `y_in` is combinational from `x_out`, with no pipeline latency; it is sampled the same cycle as the transfer.
- Last transfer at edge t: after t, `busy`=0, `x_valid`=0, `done`=1, and counters are final.
- Reset asserted mid-sweep: every register clears immediately, including the basis file. No partial results survive.

## Structure
- Package `restriction_pkg`:
  - `MISR_POLY` = 32'h04C11DB7.
  - FSM state enum `{IDLE, RUN, DONE}`.
  - Function `lowest_set_idx`.
- Sub-module `misr_accum`: MISR plus ones counter, with enable, clear and bit input.

## Test plan
- K=2, b0=0, b1=1, b2=2, `x_ready`=1, `y_in`=`x_out[0]`:
  - Points 0,1,3,2 on consecutive cycles.
  - `ones_count`=2, `signature`=0x00000006.
  - `done` rises 4 cycles after `start`.
- Same config, `x_ready` toggling 1,0,1,0…: same points, `ones_count` and `signature`. `x_out` holds during stall cycles. Sweep takes 7 cycles.
- K=2, b0=0x400000, b1=b2=0x000001, `y_in`=1:
  - Points 0x400000, 0x400001, 0x400000, 0x400001.
  - `ones_count`=4.
- Reset pulsed at the 2nd point: all outputs 0, state IDLE. A new `start` yields point `b0`=0.
- `cfg_we` writes b0=0x000005 on the same edge as `start`, with old b0=0: first point is 0. The next sweep's first point is 5.
- `start` while `busy`, and `cfg_we` while `busy`: both ignored; the sweep and basis are unchanged.

Source files
------------

// File: rtl/restriction_pkg.sv
// restriction_pkg
//   Shared definitions for the restriction sweep driver:
//     MISR_POLY      - feedback polynomial of the response MISR (CRC-32 poly)
//     state_e        - sweep FSM states
//     lowest_set_idx - index of the least significant set bit of a word,
//                      used to pick which basis vector a Gray-code step flips
package restriction_pkg;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns 0 for v == 0. Callers only pass non-zero values.
  function automatic logic [4:0] lowest_set_idx(input logic [31:0] v);
    lowest_set_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set_idx = 5'(i);
    end
  endfunction

endpackage

// File: rtl/misr_accum.sv
// misr_accum
//   Response compactor: ones counter plus MISR over a single-bit stream.
//   Ports:
//     clk, rst_n  - clock, async active-low reset
//     clr_i       - synchronous clear of both accumulators (wins over en_i)
//     en_i        - accumulate bit_i this cycle
//     bit_i       - response bit
//     ones_o      - number of accumulated ones
//     sig_o       - MISR state
module misr_accum
  import restriction_pkg::*;
#(
  parameter int CW    = 9,
  parameter int SIG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CW-1:0]    ones_o,
  output logic [SIG_W-1:0] sig_o
);

  localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

  logic [CW-1:0]    ones_q, ones_d;
  logic [SIG_W-1:0] sig_q,  sig_d;

  always_comb begin
    ones_d = ones_q;
    sig_d  = sig_q;
    if (clr_i) begin
      ones_d = '0;
      sig_d  = '0;
    end else if (en_i) begin
      ones_d = ones_q + CW'(bit_i);
      sig_d  = {sig_q[SIG_W-2:0], 1'b0}
             ^ (sig_q[SIG_W-1] ? POLY : '0)
             ^ SIG_W'(bit_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      sig_q  <= '0;
    end else begin
      ones_q <= ones_d;
      sig_q  <= sig_d;
    end
  end

  assign ones_o = ones_q;
  assign sig_o  = sig_q;

endmodule

// File: rtl/restriction_sweep_driver.sv
// restriction_sweep_driver
//   Walks every point of the affine subspace b0 ^ span(b1..bK) in Gray-code
//   order, presents each point on x_out with a valid/ready handshake, and
//   compacts the returned y_in bits into a ones count and a MISR signature.
//   Ports:
//     clk, rst_n         - clock, async active-low reset (clears basis file too)
//     cfg_we/idx/data    - basis write port; idx 0 = offset b0, 1..K = b1..bK
//     start              - begin a sweep (ignored while busy)
//     x_out, x_valid     - current point and its valid
//     x_ready            - consumer accept; transfer = x_valid & x_ready
//     y_in               - function response for x_out, sampled on transfer
//     busy, done         - sweep running / last sweep finished
//     ones_count         - count of transfers with y_in = 1
//     signature          - MISR over the y_in stream
module restriction_sweep_driver
  import restriction_pkg::*;
#(
  parameter int N_IN  = 23,
  parameter int K     = 8,
  parameter int SIG_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(K+1)-1:0]   cfg_idx,
  input  logic [N_IN-1:0]          cfg_data,
  input  logic                     start,
  output logic [N_IN-1:0]          x_out,
  output logic                     x_valid,
  input  logic                     x_ready,
  input  logic                     y_in,
  output logic                     busy,
  output logic                     done,
  output logic [K:0]               ones_count,
  output logic [SIG_W-1:0]         signature
);

  localparam int IW = $clog2(K+1);

  state_e state_q, state_d;

  logic [K:0][N_IN-1:0] basis_q;
  logic [K-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [N_IN-1:0]      x_q, x_d;
  logic [4:0]           flip_bit;
  logic [IW-1:0]        step_idx;
  logic                 start_acc, xfer, last;

  assign start_acc = start && (state_q != RUN);
  assign xfer      = (state_q == RUN) && x_ready;
  assign last      = (cnt_q == {K{1'b1}});

  // Gray code: going from n to n+1 flips the bit at the lowest set bit of
  // n+1, so exactly one basis vector is XORed in per step.
  assign cnt_inc  = cnt_q + 1'b1;
  assign flip_bit = lowest_set_idx(32'(cnt_inc));
  assign step_idx = IW'(flip_bit + 5'd1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)        state_d = RUN;
      RUN:        if (xfer && last) state_d = DONE;
      default:                      state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy    = 1'b0;
    x_valid = 1'b0;
    done    = 1'b0;
    case (state_q)
      RUN:     begin busy = 1'b1; x_valid = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- basis / offset file ----------------
  // Starting on the same edge as a write uses the old b0: the start path
  // reads basis_q before the non-blocking write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      basis_q <= '0;
    end else if (cfg_we && (state_q != RUN) && (cfg_idx <= IW'(K))) begin
      basis_q[cfg_idx] <= cfg_data;
    end
  end

  // ---------------- point generator ----------------
  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    if (start_acc) begin
      cnt_d = '0;
      x_d   = basis_q[0];
    end else if (xfer && !last) begin
      cnt_d = cnt_inc;
      x_d   = x_q ^ basis_q[step_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      x_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
    end
  end

  assign x_out = x_q;

  // ---------------- response compaction ----------------
  misr_accum #(
    .CW    (K+1),
    .SIG_W (SIG_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start_acc),
    .en_i   (xfer),
    .bit_i  (y_in),
    .ones_o (ones_count),
    .sig_o  (signature)
  );

endmodule

// File: tb/tb_restriction_sweep_driver.sv
// tb_restriction_sweep_driver
//   Directed bench for a K=2 instance. y_in is either x_out[0] or tied 1.
module tb_restriction_sweep_driver;

  localparam int N_IN  = 23;
  localparam int K     = 2;
  localparam int SIG_W = 32;
  localparam int IW    = $clog2(K+1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [IW-1:0]    cfg_idx = '0;
  logic [N_IN-1:0]  cfg_data = '0;
  logic             start = 1'b0;
  logic             x_ready = 1'b1;
  logic             y_all = 1'b0;
  logic [N_IN-1:0]  x_out;
  logic             x_valid, y_in, busy, done;
  logic [K:0]       ones_count;
  logic [SIG_W-1:0] signature;

  int n_chk = 0;
  int n_err = 0;

  restriction_sweep_driver #(.N_IN(N_IN), .K(K), .SIG_W(SIG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_data   (cfg_data),
    .start      (start),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .y_in       (y_in),
    .busy       (busy),
    .done       (done),
    .ones_count (ones_count),
    .signature  (signature)
  );

  assign y_in = y_all ? 1'b1 : x_out[0];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [N_IN-1:0] d);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full-rate sweep of 4 points, then final state checks.
  task automatic sweep4(input string tag, input logic [N_IN-1:0] e0, e1, e2, e3,
                        input logic [31:0] eones, input logic [31:0] esig);
    logic [N_IN-1:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    x_ready = 1'b1;
    go();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_pt%0d", tag, i), 32'(x_out), 32'(e[i]));
      chk($sformatf("%s_vld%0d", tag, i), 32'(x_valid), 32'd1);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_vld_end"}, 32'(x_valid), 32'd0);
    chk({tag, "_ones"}, 32'(ones_count), eones);
    chk({tag, "_sig"}, signature, esig);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N_IN-1:0] pts [4];
    int p;

    // reset state
    repeat (2) tick();
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_vld", 32'(x_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ones", 32'(ones_count), 32'd0);
    chk("rst_sig", signature, 32'd0);
    rst_n = 1'b1;
    tick();

    // basic Gray walk: 0,1,3,2 ; y = x[0] -> 0,1,1,0 -> sig 0,1,3,6
    wr(0, 23'h0); wr(1, 23'h1); wr(2, 23'h2);
    sweep4("gray", 23'h0, 23'h1, 23'h3, 23'h2, 32'd2, 32'h6);

    // stalled sweep: ready 1,0,1,0,1,0,1 -> 7 cycles, same results
    pts[0] = 23'h0; pts[1] = 23'h1; pts[2] = 23'h3; pts[3] = 23'h2;
    go();
    chk("stall_done_clr", 32'(done), 32'd0);
    p = 0;
    for (int c = 0; c < 7; c++) begin
      x_ready = (c % 2 == 0);
      chk($sformatf("stall_pt_c%0d", c), 32'(x_out), 32'(pts[p]));
      chk($sformatf("stall_vld_c%0d", c), 32'(x_valid), 32'd1);
      chk($sformatf("stall_done_c%0d", c), 32'(done), 32'd0);
      if (x_ready) p++;
      tick();
    end
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_ones", 32'(ones_count), 32'd2);
    chk("stall_sig", signature, 32'h6);
    x_ready = 1'b1;

    // dependent basis, y tied 1: sig 1,3,7,F
    y_all = 1'b1;
    wr(0, 23'h400000); wr(1, 23'h1); wr(2, 23'h1);
    sweep4("dep", 23'h400000, 23'h400001, 23'h400000, 23'h400001, 32'd4, 32'hF);
    y_all = 1'b0;

    // reset mid-sweep clears everything including the basis file
    wr(0, 23'h15); wr(1, 23'h1); wr(2, 23'h2);
    go();
    chk("mid_pt0", 32'(x_out), 32'h15);
    tick();
    chk("mid_pt1", 32'(x_out), 32'h14);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 32'(x_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_vld", 32'(x_valid), 32'd0);
    chk("mid_rst_ones", 32'(ones_count), 32'd0);
    chk("mid_rst_sig", signature, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    sweep4("post_rst", 23'h0, 23'h0, 23'h0, 23'h0, 32'd0, 32'h0);

    // write and start on the same edge: sweep uses old b0
    cfg_we = 1'b1; cfg_idx = '0; cfg_data = 23'h5; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    chk("same_edge_pt0", 32'(x_out), 32'h0);
    repeat (4) tick();
    chk("same_edge_done", 32'(done), 32'd1);
    wr(1, 23'h1); wr(2, 23'h2);

    // start and cfg_we while busy are both ignored: 5,4,6,7
    go();
    chk("busy_pt0", 32'(x_out), 32'h5);
    start = 1'b1; cfg_we = 1'b1; cfg_idx = '0; cfg_data = 23'h7;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    chk("busy_pt1", 32'(x_out), 32'h4);
    tick();
    chk("busy_pt2", 32'(x_out), 32'h6);
    tick();
    chk("busy_pt3", 32'(x_out), 32'h7);
    chk("busy_still", 32'(busy), 32'd1);
    tick();
    chk("busy_done", 32'(done), 32'd1);
    // y = x[0]: 1,0,0,1 -> sig 1,2,4,9
    chk("busy_ones", 32'(ones_count), 32'd2);
    chk("busy_sig", signature, 32'h9);
    sweep4("basis_kept", 23'h5, 23'h4, 23'h6, 23'h7, 32'd2, 32'h9);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
